// File: rtl/spram32_arb_pkg.sv
// ============================================================================
// Module      : spram32_arb_pkg
// Description : Shared types and defaults for the eForth1 SPRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spram32_arb_pkg;

    // Who owns the read data returning from the SPRAM this cycle
    typedef enum logic [1:0] {
        NONE = 2'd0,
        M0   = 2'd1,
        M1   = 2'd2
    } arb_own_e;

    localparam int WAIT_MAX_DEF = 8;
    localparam int AW_DEF       = 15;

endpackage : spram32_arb_pkg

`default_nettype wire

// File: rtl/spram32_arb_age.sv
// ============================================================================
// Module      : spram32_arb_age
// Description : Saturating wait counter that forces an m1 win after WAIT_MAX
//               consecutive refused cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram32_arb_age
    import spram32_arb_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req1,
    input  logic gnt1,
    output logic force1
);

    localparam logic [7:0] c_wait_max = 8'(WAIT_MAX);

    logic [7:0] age_q;
    logic [7:0] age_d;

    always_comb begin
        age_d = age_q;
        if (!req1 || gnt1) begin
            age_d = 8'd0;
        end else if (age_q != c_wait_max) begin
            age_d = age_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= 8'd0;
        end else begin
            age_q <= age_d;
        end
    end

    assign force1 = (age_q == c_wait_max);

endmodule : spram32_arb_age

`default_nettype wire

// File: rtl/spram32_arb.sv
// ============================================================================
// Module      : spram32_arb
// Description : Two-master arbiter for the 32-bit SPRAM: fixed m0 priority,
//               one access per cycle, read data routed back to its owner.
//               Define SPRAM32_ARB_AGE_EN to add the m1 aging counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spram32_arb
    import spram32_arb_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    // master 0 (eForth core)
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_ai,
    input  logic [31:0]   m0_vi,
    input  logic [3:0]    m0_bmsk,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_vo,
    // master 1 (loader / DMA)
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_ai,
    input  logic [31:0]   m1_vi,
    input  logic [3:0]    m1_bmsk,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_vo,
    // memory side
    output logic [AW-1:0] mem_ai,
    output logic [31:0]   mem_vi,
    output logic [3:0]    mem_bmsk,
    output logic          mem_we,
    input  logic [31:0]   mem_vo
);

    if ((WAIT_MAX < 1) || (WAIT_MAX > 255)) begin : g_wait_max_range
        $error("spram32_arb: WAIT_MAX must be in 1..255");
    end

    logic     w_force1;
    logic     w_gnt0;
    logic     w_gnt1;
    arb_own_e own_q;
    arb_own_e own_d;

`ifdef SPRAM32_ARB_AGE_EN
    spram32_arb_age #(
        .WAIT_MAX (WAIT_MAX)
    ) u_age (
        .clk    (clk),
        .rst_n  (rst_n),
        .req1   (m1_req),
        .gnt1   (w_gnt1),
        .force1 (w_force1)
    );
`else
    assign w_force1 = 1'b0;
`endif

    // Nothing is accepted while reset is held, so the memory is never written
    assign w_gnt1 = rst_n && m1_req && (!m0_req || w_force1);
    assign w_gnt0 = rst_n && m0_req && !w_gnt1;

    assign m0_gnt = w_gnt0;
    assign m1_gnt = w_gnt1;

    always_comb begin
        mem_ai   = m0_ai;
        mem_vi   = m0_vi;
        mem_bmsk = 4'd0;
        mem_we   = 1'b0;
        own_d    = NONE;
        if (w_gnt1) begin
            mem_ai   = m1_ai;
            mem_vi   = m1_vi;
            mem_bmsk = m1_bmsk;
            mem_we   = m1_we;
            if (!m1_we) begin
                own_d = M1;
            end
        end else if (w_gnt0) begin
            mem_bmsk = m0_bmsk;
            mem_we   = m0_we;
            if (!m0_we) begin
                own_d = M0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q <= NONE;
        end else begin
            own_q <= own_d;
        end
    end

    // SPRAM returns read data one cycle after the access; own_q tags it
    assign m0_rvalid = (own_q == M0);
    assign m1_rvalid = (own_q == M1);
    assign m0_vo     = m0_rvalid ? mem_vo : 32'd0;
    assign m1_vo     = m1_rvalid ? mem_vo : 32'd0;

endmodule : spram32_arb

`default_nettype wire

// File: tb/tb_spram32_arb.sv
// ============================================================================
// Module      : tb_spram32_arb
// Description : Self-checking bench for spram32_arb with an SPRAM model and a
//               cycle-level reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spram32_arb;

    localparam int WAIT_MAX = 8;
    localparam int AW       = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_ai, m1_ai;
    logic [31:0]   m0_vi, m1_vi;
    logic [3:0]    m0_bmsk, m1_bmsk;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_vo, m1_vo;
    logic [AW-1:0] mem_ai;
    logic [31:0]   mem_vi;
    logic [3:0]    mem_bmsk;
    logic          mem_we;
    logic [31:0]   mem_vo;

    always #5 clk = ~clk;

    spram32_arb #(
        .WAIT_MAX (WAIT_MAX),
        .AW       (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_ai     (m0_ai),
        .m0_vi     (m0_vi),
        .m0_bmsk   (m0_bmsk),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_vo     (m0_vo),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_ai     (m1_ai),
        .m1_vi     (m1_vi),
        .m1_bmsk   (m1_bmsk),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_vo     (m1_vo),
        .mem_ai    (mem_ai),
        .mem_vi    (mem_vi),
        .mem_bmsk  (mem_bmsk),
        .mem_we    (mem_we),
        .mem_vo    (mem_vo)
    );

    // Behavioural SPRAM: byte-masked synchronous write, registered read
    logic [31:0] spram [0:32767];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_bmsk[b]) spram[mem_ai][8*b +: 8] <= mem_vi[8*b +: 8];
            end
        end
        mem_vo <= spram[mem_ai];
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [0:32767];
    int          refused;
    bit          exp_rv0, exp_rv1;
    logic [31:0] exp_d0, exp_d1;
    bit          last_g0, last_g1;
    bit          dut_g1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] msk);
        logic [31:0] r = old_v;
        for (int b = 0; b < 4; b++) if (msk[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // One clock: check outputs at negedge against the model, advance the model
    task automatic step();
        bit          frc, e_g0, e_g1;
        logic [31:0] nd0, nd1;
        @(negedge clk);
        if (!rst_n) begin
            exp_rv0 = 1'b0;
            exp_rv1 = 1'b0;
            refused = 0;
        end
`ifdef SPRAM32_ARB_AGE_EN
        frc = (refused >= WAIT_MAX);
`else
        frc = 1'b0;
`endif
        e_g1 = rst_n && m1_req && (!m0_req || frc);
        e_g0 = rst_n && m0_req && !e_g1;
        chk("m0_gnt", m0_gnt, e_g0);
        chk("m1_gnt", m1_gnt, e_g1);
        chk("mem_we", mem_we, (e_g0 && m0_we) || (e_g1 && m1_we));
        chk("m0_rvalid", m0_rvalid, exp_rv0);
        chk("m1_rvalid", m1_rvalid, exp_rv1);
        chk("m0_vo", m0_vo, exp_rv0 ? exp_d0 : 32'd0);
        chk("m1_vo", m1_vo, exp_rv1 ? exp_d1 : 32'd0);
        if (e_g1)      chk("mem_ai_m1", mem_ai, m1_ai);
        else if (e_g0) chk("mem_ai_m0", mem_ai, m0_ai);
        else           chk("mem_bmsk_idle", mem_bmsk, 32'd0);
        dut_g1 = m1_gnt;
        nd0 = ref_mem[m0_ai];
        nd1 = ref_mem[m1_ai];
        if (e_g0 && m0_we) ref_mem[m0_ai] = merge(ref_mem[m0_ai], m0_vi, m0_bmsk);
        if (e_g1 && m1_we) ref_mem[m1_ai] = merge(ref_mem[m1_ai], m1_vi, m1_bmsk);
        exp_rv0 = e_g0 && !m0_we;
        exp_rv1 = e_g1 && !m1_we;
        exp_d0  = nd0;
        exp_d1  = nd1;
        if (rst_n && m1_req && !e_g1) refused = (refused < WAIT_MAX) ? refused + 1 : WAIT_MAX;
        else                          refused = 0;
        last_g0 = e_g0;
        last_g1 = e_g1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] ai,
                          input logic [31:0] vi, input logic [3:0] bm);
        m0_req = req; m0_we = we; m0_ai = ai; m0_vi = vi; m0_bmsk = bm;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] ai,
                          input logic [31:0] vi, input logic [3:0] bm);
        m1_req = req; m1_we = we; m1_ai = ai; m1_vi = vi; m1_bmsk = bm;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 15'h0000;
            1: return 15'h3FFF;
            2: return 15'h4000;
            3: return 15'h4001;
            4: return 15'h7FFF;
            default: return 15'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [3:0] pick_bmsk();
        case ($urandom_range(0, 3))
            0: return 4'h0;
            1: return 4'hF;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        int cnt_g1;
        int first_g1;
        for (int i = 0; i < 32768; i++) begin
            spram[i]   = 32'd0;
            ref_mem[i] = 32'd0;
        end
        refused = 0;
        exp_rv0 = 1'b0; exp_rv1 = 1'b0;
        exp_d0  = 32'd0; exp_d1 = 32'd0;

        // reset with both masters requesting writes: memory must not be touched
        rst_n = 1'b0;
        set_m0(1'b1, 1'b1, 15'h0010, 32'h0BAD0BAD, 4'hF);
        set_m1(1'b1, 1'b1, 15'h0011, 32'h0BAD0BAD, 4'hF);
        repeat (3) step();
        rst_n = 1'b1;
        set_m0(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        step();

        // m1 alone: write then read across the upper bank pair
        set_m1(1'b1, 1'b1, 15'h4001, 32'hDEADBEEF, 4'hF);
        step();
        set_m1(1'b1, 1'b0, 15'h4001, 32'h0, 4'h0);
        step();
        chk("m1_read_4001", m1_vo, 32'hDEADBEEF);
        set_m1(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        step();

        // byte-masked overwrite
        set_m0(1'b1, 1'b1, 15'h0000, 32'h11223344, 4'hF);
        step();
        set_m0(1'b1, 1'b1, 15'h0000, 32'hAABBCCDD, 4'b0101);
        step();
        set_m0(1'b1, 1'b0, 15'h0000, 32'h0, 4'h0);
        step();
        chk("bmsk_read", m0_vo, 32'h11BB33DD);

        // zero-mask write consumes a cycle but changes nothing
        set_m0(1'b1, 1'b1, 15'h0000, 32'hFFFFFFFF, 4'h0);
        step();
        set_m0(1'b1, 1'b0, 15'h0000, 32'h0, 4'h0);
        step();
        chk("bmsk0_read", m0_vo, 32'h11BB33DD);

        // back-to-back write then read at top address
        set_m0(1'b1, 1'b1, 15'h7FFF, 32'hCAFEF00D, 4'hF);
        step();
        set_m0(1'b1, 1'b0, 15'h7FFF, 32'h0, 4'h0);
        step();
        chk("b2b_read_7fff", m0_vo, 32'hCAFEF00D);
        set_m0(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        step();

        // contention: both read every cycle
        set_m0(1'b1, 1'b0, 15'h3FFF, 32'h0, 4'h0);
        set_m1(1'b1, 1'b0, 15'h4000, 32'h0, 4'h0);
        cnt_g1   = 0;
        first_g1 = 0;
        for (int c = 1; c <= 3 * (WAIT_MAX + 1); c++) begin
            step();
            if (dut_g1) begin
                cnt_g1++;
                if (first_g1 == 0) first_g1 = c;
            end
        end
`ifdef SPRAM32_ARB_AGE_EN
        chk("m1_wins", 32'(cnt_g1), 32'd3);
        chk("m1_first_win", 32'(first_g1), 32'(WAIT_MAX + 1));
`else
        chk("m1_wins", 32'(cnt_g1), 32'd0);
`endif
        set_m0(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        step();

        // reset right after an m0 read grant discards the read
        set_m0(1'b1, 1'b0, 15'h7FFF, 32'h0, 4'h0);
        step();
        set_m0(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // randomized traffic; masters hold a request until granted
        for (int c = 0; c < 3000; c++) begin
            if (!m0_req || last_g0) begin
                if ($urandom_range(0, 9) < 8)
                    set_m0(1'b1, 1'($urandom), pick_addr(), $urandom, pick_bmsk());
                else
                    set_m0(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
            end
            if (!m1_req || last_g1) begin
                if ($urandom_range(0, 9) < 6)
                    set_m1(1'b1, 1'($urandom), pick_addr(), $urandom, pick_bmsk());
                else
                    set_m1(1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
            end
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spram32_arb

`default_nettype wire
